// File: rtl/uart_cmd_parser.sv
// Frame parser for the Bluetooth UART byte stream: <START CMD ARG CHK END>.
// Validates checksum and end delimiter, enforces an inter-byte timeout, strobes results.
module uart_cmd_parser #(
  parameter logic [7:0] START_BYTE     = 8'h3C,
  parameter logic [7:0] END_BYTE       = 8'h3E,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter int         TO_W           = 20
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] RxData,
  input  logic       RxDone,
  output logic       CmdValid,
  output logic [7:0] Cmd,
  output logic [7:0] Arg,
  output logic       FrameErr,
  output logic [1:0] ErrCode,
  output logic       Busy,
  output logic [7:0] FrameCount
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_ARG = 3'd2,
    GET_CHK = 3'd3,
    GET_END = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_END  = 2'd2;
  localparam logic [1:0] ERR_TOUT = 2'd3;

  // Frame checksum: plain XOR of command and argument.
  function automatic logic [7:0] calcChk(input logic [7:0] c, input logic [7:0] a);
    return c ^ a;
  endfunction

  state_t          stateR;
  logic            rxdR;
  logic [TO_W-1:0] toCntR;
  logic [7:0]      cmdR;
  logic [7:0]      argR;
  logic            byteEvtS;
  logic            toExpireS;

  // RxDone may stay high for several cycles; only its rising edge counts as a byte.
  assign byteEvtS  = RxDone & ~rxdR;
  assign toExpireS = (stateR != IDLE) && !byteEvtS && (toCntR == TO_LAST);

  // RxDone edge history.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rxdR <= 1'b0;
    end else begin
      rxdR <= RxDone;
    end
  end

  // Inter-byte timeout counter; idle frames never age.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      toCntR <= '0;
    end else if (byteEvtS || (stateR == IDLE) || toExpireS) begin
      toCntR <= '0;
    end else begin
      toCntR <= toCntR + {{(TO_W-1){1'b0}}, 1'b1};
    end
  end

  // Frame FSM with registered strobes and held result registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateR     <= IDLE;
      cmdR       <= 8'h00;
      argR       <= 8'h00;
      CmdValid   <= 1'b0;
      Cmd        <= 8'h00;
      Arg        <= 8'h00;
      FrameErr   <= 1'b0;
      ErrCode    <= 2'd0;
      Busy       <= 1'b0;
      FrameCount <= 8'h00;
    end else begin
      CmdValid <= 1'b0;
      FrameErr <= 1'b0;
      if (toExpireS) begin
        FrameErr <= 1'b1;
        ErrCode  <= ERR_TOUT;
        stateR   <= IDLE;
        Busy     <= 1'b0;
      end else if (byteEvtS) begin
        case (stateR)
          IDLE: begin
            if (RxData == START_BYTE) begin
              stateR <= GET_CMD;
              Busy   <= 1'b1;
            end else begin
              stateR <= IDLE;
              Busy   <= 1'b0;
            end
          end
          GET_CMD: begin
            cmdR   <= RxData;
            stateR <= GET_ARG;
          end
          GET_ARG: begin
            argR   <= RxData;
            stateR <= GET_CHK;
          end
          GET_CHK: begin
            if (RxData == calcChk(cmdR, argR)) begin
              stateR <= GET_END;
            end else begin
              FrameErr <= 1'b1;
              ErrCode  <= ERR_CHK;
              stateR   <= IDLE;
              Busy     <= 1'b0;
            end
          end
          GET_END: begin
            // The byte is consumed either way; a bad END never restarts a frame.
            if (RxData == END_BYTE) begin
              CmdValid   <= 1'b1;
              Cmd        <= cmdR;
              Arg        <= argR;
              FrameCount <= FrameCount + 8'd1;
            end else begin
              FrameErr <= 1'b1;
              ErrCode  <= ERR_END;
            end
            stateR <= IDLE;
            Busy   <= 1'b0;
          end
          default: begin
            stateR <= IDLE;
            Busy   <= 1'b0;
          end
        endcase
      end else begin
        stateR <= stateR;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected strobes, a monitor pops them.
module tb_uart_cmd_parser;

  localparam int TOUT = 100;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] RxData;
  logic       RxDone;
  logic       CmdValid;
  logic [7:0] Cmd;
  logic [7:0] Arg;
  logic       FrameErr;
  logic [1:0] ErrCode;
  logic       Busy;
  logic [7:0] FrameCount;

  uart_cmd_parser #(
    .START_BYTE    (8'h3C),
    .END_BYTE      (8'h3E),
    .TIMEOUT_CYCLES(TOUT),
    .TO_W          (20)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .RxData    (RxData),
    .RxDone    (RxDone),
    .CmdValid  (CmdValid),
    .Cmd       (Cmd),
    .Arg       (Arg),
    .FrameErr  (FrameErr),
    .ErrCode   (ErrCode),
    .Busy      (Busy),
    .FrameCount(FrameCount)
  );

  always #5 Clk = ~Clk;

  int cycCnt = 0;
  always @(posedge Clk) cycCnt <= cycCnt + 1;

  typedef struct {
    logic       isErr;
    logic [7:0] cmd;
    logic [7:0] arg;
    logic [1:0] code;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t expQ[$];
  int nChecks = 0;
  int nFails  = 0;

  // Model of the held output registers.
  logic [7:0] mCmd = 8'h00;
  logic [7:0] mArg = 8'h00;
  logic [1:0] mCode = 2'd0;
  logic [7:0] mCnt = 8'h00;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void modelReset();
    mCmd  = 8'h00;
    mArg  = 8'h00;
    mCode = 2'd0;
    mCnt  = 8'h00;
  endfunction

  function automatic void pushValid(input logic [7:0] c, input logic [7:0] a);
    exp_t e;
    mCmd = c;
    mArg = a;
    mCnt = mCnt + 8'd1;
    e = '{1'b0, mCmd, mArg, mCode, mCnt, -1};
    expQ.push_back(e);
  endfunction

  function automatic void pushErr(input logic [1:0] code, input int cyc);
    exp_t e;
    mCode = code;
    e = '{1'b1, mCmd, mArg, mCode, mCnt, cyc};
    expQ.push_back(e);
  endfunction

  // Monitor: every strobe must match the oldest pending expectation.
  always @(negedge Clk) begin
    if (Rst_n && (CmdValid || FrameErr)) begin
      check("strobe_exclusive", {31'd0, CmdValid & FrameErr}, 32'd0);
      if (expQ.size() == 0) begin
        check("unexpected_strobe", {30'd0, CmdValid, FrameErr}, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("strobe_kind", {31'd0, FrameErr}, {31'd0, e.isErr});
        check("Cmd", {24'd0, Cmd}, {24'd0, e.cmd});
        check("Arg", {24'd0, Arg}, {24'd0, e.arg});
        check("ErrCode", {30'd0, ErrCode}, {30'd0, e.code});
        check("FrameCount", {24'd0, FrameCount}, {24'd0, e.cnt});
        if (e.cyc >= 0) check("strobe_cycle", cycCnt, e.cyc);
      end
    end
  end

  task automatic sendAt(input logic [7:0] b, input int w, input int target, output int evt);
    do begin
      @(posedge Clk);
      #1;
    end while (cycCnt < target);
    evt    = cycCnt;
    RxData = b;
    RxDone = 1'b1;
    repeat (w) begin
      @(posedge Clk);
      #1;
    end
    RxDone = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int w);
    int evt;
    sendAt(b, w, cycCnt + 1, evt);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    check({tag, "_CmdValid"}, {31'd0, CmdValid}, 32'd0);
    check({tag, "_Cmd"}, {24'd0, Cmd}, 32'd0);
    check({tag, "_Arg"}, {24'd0, Arg}, 32'd0);
    check({tag, "_FrameErr"}, {31'd0, FrameErr}, 32'd0);
    check({tag, "_ErrCode"}, {30'd0, ErrCode}, 32'd0);
    check({tag, "_Busy"}, {31'd0, Busy}, 32'd0);
    check({tag, "_FrameCount"}, {24'd0, FrameCount}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1;
    int e2;
    int dummy;
    logic [7:0] c;
    logic [7:0] a;
    Rst_n  = 1'b0;
    RxData = 8'h00;
    RxDone = 1'b0;
    idle(3);
    checkZeroOutputs("reset");
    Rst_n = 1'b1;
    idle(2);

    // Valid frame with 3-cycle RxDone pulses.
    sendByte(8'h3C, 3);
    idle(1);
    check("busy_in_frame", {31'd0, Busy}, 32'd1);
    sendByte(8'h41, 3);
    sendByte(8'h05, 3);
    sendByte(8'h44, 3);
    pushValid(8'h41, 8'h05);
    sendByte(8'h3E, 3);
    idle(3);
    check("busy_after_valid", {31'd0, Busy}, 32'd0);

    // Bad checksum; trailing END ignored in IDLE.
    sendByte(8'h3C, 1);
    sendByte(8'h41, 1);
    sendByte(8'h05, 1);
    pushErr(2'd1, -1);
    sendByte(8'h45, 1);
    sendByte(8'h3E, 1);
    idle(3);
    check("busy_after_chk_err", {31'd0, Busy}, 32'd0);

    // Bad END byte equal to START: consumed, no resync.
    sendByte(8'h3C, 2);
    sendByte(8'h10, 2);
    sendByte(8'h20, 2);
    sendByte(8'h30, 2);
    pushErr(2'd2, -1);
    sendByte(8'h3C, 2);
    idle(2);
    check("busy_after_end_err", {31'd0, Busy}, 32'd0);
    sendByte(8'h3C, 1);
    sendByte(8'h10, 1);
    sendByte(8'h20, 1);
    sendByte(8'h30, 1);
    pushValid(8'h10, 8'h20);
    sendByte(8'h3E, 1);
    idle(3);

    // Timeout: strobe 100 clock edges after the edge that consumed the 41.
    sendByte(8'h3C, 1);
    sendAt(8'h41, 1, cycCnt + 1, e1);
    pushErr(2'd3, e1 + 1 + TOUT);
    idle(TOUT + 5);
    check("busy_after_timeout", {31'd0, Busy}, 32'd0);

    // Byte event on the expiry cycle is processed instead of timing out.
    sendByte(8'h3C, 1);
    sendAt(8'h41, 1, cycCnt + 1, e2);
    sendAt(8'h05, 1, e2 + TOUT, dummy);
    sendByte(8'h44, 1);
    pushValid(8'h41, 8'h05);
    sendByte(8'h3E, 1);
    idle(3);

    // Asynchronous reset mid-frame.
    sendByte(8'h3C, 1);
    sendByte(8'h41, 1);
    sendByte(8'h05, 1);
    #2;
    Rst_n = 1'b0;
    #1;
    modelReset();
    checkZeroOutputs("async_reset");
    idle(2);
    Rst_n = 1'b1;
    idle(1);
    sendByte(8'h05, 1);
    sendByte(8'h44, 1);
    sendByte(8'h3E, 1);
    idle(2);
    check("post_reset_busy", {31'd0, Busy}, 32'd0);
    sendByte(8'h3C, 1);
    sendByte(8'h22, 1);
    sendByte(8'h33, 1);
    sendByte(8'h11, 1);
    pushValid(8'h22, 8'h33);
    sendByte(8'h3E, 1);
    idle(3);
    check("post_reset_count", {24'd0, FrameCount}, 32'd1);

    // 256 frames from a clean count, with idle noise between some of them.
    Rst_n = 1'b0;
    #1;
    modelReset();
    idle(2);
    Rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 256; i++) begin
      c = i[7:0];
      a = 8'hA5 + i[7:0];
      if (i % 4 == 0) begin
        sendByte(8'h00, 1);
        sendByte(8'hFF, 1);
        sendByte(8'h3E, 1);
      end
      sendByte(8'h3C, 1);
      sendByte(c, 1);
      sendByte(a, 1);
      sendByte(c ^ a, 1);
      pushValid(c, a);
      sendByte(8'h3E, 1);
    end
    idle(4);
    check("wrap_count", {24'd0, FrameCount}, 32'd0);
    check("wrap_cmd", {24'd0, Cmd}, 32'd255);
    check("pending_expectations", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the byte stream delivered by the UART receive path (RxData plus RxDone) from the HC-06 Bluetooth link at 9600 baud.
- Assembles fixed 5-byte command frames, validates start, checksum and end bytes, and applies an inter-byte timeout.
- Presents each valid command/argument pair to the disinfection/access control logic as a one-cycle strobe.
- Sits directly downstream of the UART receiver, in the same clock domain.

Parameters:
- START_BYTE, 8'h3C, frame start delimiter '<'.
- END_BYTE, 8'h3E, frame end delimiter '>'.
- TIMEOUT_CYCLES, 500000, max clocks between consecutive bytes inside a frame (10 ms at 50 MHz).
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  reset; asynchronous, active-low.
- RxData  in  8  received byte; valid while RxDone is high.
- RxDone  in  1  reception complete; may stay high for multiple cycles.
- CmdValid  out  1  one-cycle pulse: Cmd/Arg hold a newly validated frame.
- Cmd  out  8  command byte of the last valid frame; held until the next valid frame.
- Arg  out  8  argument byte of the last valid frame; held until the next valid frame.
- FrameErr  out  1  one-cycle pulse: frame discarded.
- ErrCode  out  2  reason for the last FrameErr: 1 = checksum, 2 = bad end byte, 3 = timeout; held until the next error.
- Busy  out  1  high while in any state other than IDLE.
- FrameCount  out  8  count of valid frames; wraps 255 -> 0.

Behaviour:
- Clock/reset: one clock, Clk. Reset is asynchronous, active-low on Rst_n.
- Reset values: all outputs 0; state = IDLE; timeout counter = 0; RxDone history register = 0.
- Byte event: rxd_q registers RxDone each cycle. A byte event is RxDone & ~rxd_q. Exactly one event per RxDone high period regardless of its length.
- Frame format: START, CMD, ARG, CHK, END, where CHK = CMD ^ ARG.
- FSM states: IDLE, GET_CMD, GET_ARG, GET_CHK, GET_END. Transitions occur only on a byte event, except timeout.
  - IDLE: byte == START_BYTE -> GET_CMD. Any other byte is ignored silently.
  - GET_CMD: latch byte into an internal cmd_r -> GET_ARG. The byte value is literal; START_BYTE is not special here.
  - GET_ARG: latch arg_r -> GET_CHK.
  - GET_CHK: if byte == cmd_r ^ arg_r -> GET_END. Otherwise FrameErr, ErrCode = 1 -> IDLE.
  - GET_END: if byte == END_BYTE, update Cmd/Arg from cmd_r/arg_r, pulse CmdValid, increment FrameCount, -> IDLE. Otherwise FrameErr, ErrCode = 2 -> IDLE; the offending byte is consumed, with no resync even if it equals START_BYTE.
- Latency: the byte event is detected in cycle N. CmdValid/FrameErr are high during cycle N+1 only. Cmd, Arg, ErrCode and FrameCount are updated in the same cycle as their strobe.
- CmdValid and FrameErr are never high in the same cycle.
- Timeout counter:
  - Cleared on every byte event and while in IDLE; otherwise increments.
  - Reaching TIMEOUT_CYCLES-1 with no byte event in that cycle -> FrameErr, ErrCode = 3, -> IDLE, counter cleared.
  - A byte event in the same cycle as expiry takes priority: the byte is processed normally and the counter is cleared.
- Cmd/Arg are not modified by errors or timeouts.
- Busy reflects the registered state, i.e. it is high starting the cycle after the START byte event.
- Rst_n assertion mid-frame returns the FSM immediately to IDLE and clears all outputs, including Cmd, Arg and FrameCount. The partial frame is lost.
- FrameCount: 8-bit unsigned, modulo-256 increment.

Test Plan:
- Bytes 3C,41,05,44,3E with RxDone pulses 3 cycles wide -> one CmdValid pulse; Cmd = 8'h41, Arg = 8'h05, FrameCount = 1, FrameErr never asserted.
- Bytes 3C,41,05,45,3E -> FrameErr pulse at the CHK byte (+1 cycle), ErrCode = 1. The trailing 3E is ignored in IDLE. Cmd/Arg keep their previous values.
- Bytes 3C,10,20,30,3C -> FrameErr, ErrCode = 2, Busy low afterwards. A following frame 3C,10,20,30,3E is accepted with Cmd = 8'h10.
- Bytes 3C,41 then silence (TIMEOUT_CYCLES set to 100 in the bench) -> FrameErr, ErrCode = 3, exactly 100 cycles after the 41 event; Busy falls. A byte event landing exactly on the expiry cycle is processed and no FrameErr occurs.
- 256 valid frames back-to-back -> FrameCount wraps to 0, 256 CmdValid pulses. Noise bytes (00, FF, 3E) between frames while in IDLE produce no strobes.
- Rst_n pulled low after 3C,41,05 -> outputs zero asynchronously. After release, 05,44,3E produce nothing; a full frame then succeeds.
